// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use stall FSM; WB_BYPASS_EN adds writeback bypass
module id_ex_stage #(
    parameter int CTL_W             = 9,
    parameter int LOAD_STALL_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [31:0]      id_instr,
    input  logic [31:0]      id_npc,
    input  logic [CTL_W-1:0] id_ctl,
    input  logic [31:0]      A_readdat1,
    input  logic [31:0]      B_readdat2,
    input  logic             wb_regwrite,
    input  logic [4:0]       wb_rd,
    input  logic [31:0]      wb_writedata,
    input  logic             ext_stall,
    input  logic             flush,
    output logic             stall,
    output logic             ex_valid,
    output logic [CTL_W-1:0] ex_ctl,
    output logic [31:0]      ex_A,
    output logic [31:0]      ex_B,
    output logic [31:0]      ex_imm,
    output logic [4:0]       ex_rs,
    output logic [4:0]       ex_rt,
    output logic [4:0]       ex_rd,
    output logic [4:0]       ex_shamt,
    output logic [31:0]      ex_npc
);

    typedef enum logic {RUN, HOLD} state_t;

    localparam logic [2:0] RELOAD = 3'(LOAD_STALL_CYCLES - 1);

    state_t      state;
    logic [2:0]  cnt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        hz;
    logic        capture;
    logic        bubble;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        unused_opcode;

    assign rs = id_instr[25:21];
    assign rt = id_instr[20:16];
    assign unused_opcode = &{1'b0, id_instr[31:26]};

`ifdef WB_BYPASS_EN
    // Register file writes at the edge but reads asynchronously; forward the in-flight write.
    assign op_a = (wb_regwrite && wb_rd == rs && rs != 5'd0) ? wb_writedata : A_readdat1;
    assign op_b = (wb_regwrite && wb_rd == rt && rt != 5'd0) ? wb_writedata : B_readdat2;
`else
    logic unused_wb;
    assign unused_wb = &{1'b0, wb_regwrite, wb_rd, wb_writedata};
    assign op_a = A_readdat1;
    assign op_b = B_readdat2;
`endif

    assign hz = (state == RUN) && ex_valid && ex_ctl[6] && (ex_rt != 5'd0) && id_valid &&
                ((ex_rt == rs) || (ex_rt == rt)) && !flush;

    assign stall   = rst && (ext_stall || (!flush && (hz || state == HOLD)));
    assign capture = !ext_stall && !flush && (state == RUN) && !hz && id_valid;
    assign bubble  = !ext_stall && !capture;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            cnt   <= 3'd0;
        end else if (!ext_stall) begin
            if (flush) begin
                state <= RUN;
                cnt   <= 3'd0;
            end else if (state == HOLD) begin
                cnt <= cnt - 3'd1;
                if (cnt == 3'd1) state <= RUN;
            end else if (hz && LOAD_STALL_CYCLES > 1) begin
                cnt   <= RELOAD;
                state <= HOLD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid <= 1'b0;
            ex_ctl   <= '0;
            ex_A     <= '0;
            ex_B     <= '0;
            ex_imm   <= '0;
            ex_rs    <= '0;
            ex_rt    <= '0;
            ex_rd    <= '0;
            ex_shamt <= '0;
            ex_npc   <= '0;
        end else if (capture) begin
            ex_valid <= 1'b1;
            ex_ctl   <= id_ctl;
            ex_A     <= op_a;
            ex_B     <= op_b;
            ex_imm   <= {{16{id_instr[15]}}, id_instr[15:0]};
            ex_rs    <= rs;
            ex_rt    <= rt;
            ex_rd    <= id_instr[15:11];
            ex_shamt <= id_instr[10:6];
            ex_npc   <= id_npc;
        end else if (bubble) begin
            ex_valid <= 1'b0;
            ex_ctl   <= '0;
            ex_A     <= '0;
            ex_B     <= '0;
            ex_imm   <= '0;
            ex_rs    <= '0;
            ex_rt    <= '0;
            ex_rd    <= '0;
            ex_shamt <= '0;
            ex_npc   <= '0;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage (LOAD_STALL_CYCLES 1 and 3)
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic [8:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [31:0] npc;
    } ex_t;

    typedef struct {
        int   due;
        int   inst;
        bit   is_ex;
        logic s;
        ex_t  e;
    } exp_t;

    localparam int BUB = 0, CAP = 1, HLD = 2;
    localparam logic [31:0] LW   = 32'h8C220004;
    localparam logic [31:0] LWN  = 32'h8C22FFFC;
    localparam logic [31:0] ADD  = 32'h00441820;
    localparam logic [31:0] SUB  = 32'h00C72822;
    localparam logic [31:0] LW0  = 32'h8C200004;
    localparam logic [31:0] ADD0 = 32'h00041820;
    localparam logic [31:0] BYA  = 32'h00A60820;
    localparam logic [31:0] BYB  = 32'h00050820;
    localparam logic [8:0]  CLW  = 9'h1C4;
    localparam logic [8:0]  CADD = 9'h10A;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_instr, id_npc, a_rd, b_rd, wb_writedata;
    logic [8:0]  id_ctl;
    logic        wb_regwrite, ext_stall, flush;
    logic [4:0]  wb_rd;

    logic        s1, v1, s3, v3;
    logic [8:0]  c1, c3;
    logic [31:0] a1, b1, i1, n1, a3, b3, i3, n3;
    logic [4:0]  rs1, rt1, rd1, sh1, rs3, rt3, rd3, sh3;
    ex_t         act1, act3;

    exp_t q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    ex_t  last1, last3;
    logic [31:0] ga = 32'h0, gb = 32'h0, gwbd = 32'h0;
    logic        gwbw = 1'b0;
    logic [4:0]  gwbrd = 5'd0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    id_ex_stage #(.CTL_W(9), .LOAD_STALL_CYCLES(1)) u1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .id_npc(id_npc),
        .id_ctl(id_ctl), .A_readdat1(a_rd), .B_readdat2(b_rd), .wb_regwrite(wb_regwrite),
        .wb_rd(wb_rd), .wb_writedata(wb_writedata), .ext_stall(ext_stall), .flush(flush),
        .stall(s1), .ex_valid(v1), .ex_ctl(c1), .ex_A(a1), .ex_B(b1), .ex_imm(i1),
        .ex_rs(rs1), .ex_rt(rt1), .ex_rd(rd1), .ex_shamt(sh1), .ex_npc(n1));

    id_ex_stage #(.CTL_W(9), .LOAD_STALL_CYCLES(3)) u3 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .id_npc(id_npc),
        .id_ctl(id_ctl), .A_readdat1(a_rd), .B_readdat2(b_rd), .wb_regwrite(wb_regwrite),
        .wb_rd(wb_rd), .wb_writedata(wb_writedata), .ext_stall(ext_stall), .flush(flush),
        .stall(s3), .ex_valid(v3), .ex_ctl(c3), .ex_A(a3), .ex_B(b3), .ex_imm(i3),
        .ex_rs(rs3), .ex_rt(rt3), .ex_rd(rd3), .ex_shamt(sh3), .ex_npc(n3));

    assign act1 = {v1, c1, a1, b1, i1, rs1, rt1, rd1, sh1, n1};
    assign act3 = {v3, c3, a3, b3, i3, rs3, rt3, rd3, sh3, n3};

    function automatic void push(input int due, input int inst, input bit is_ex,
                                 input logic s, input ex_t e);
        exp_t x;
        x.due = due; x.inst = inst; x.is_ex = is_ex; x.s = s; x.e = e;
        q.push_back(x);
    endfunction

    // Expected EX contents when the current ID inputs are captured.
    function automatic ex_t cap();
        ex_t e;
        e = '0;
        if (id_valid) begin
            e.valid = 1'b1;
            e.ctl   = id_ctl;
            e.rs    = id_instr[25:21];
            e.rt    = id_instr[20:16];
            e.rd    = id_instr[15:11];
            e.shamt = id_instr[10:6];
            e.imm   = {{16{id_instr[15]}}, id_instr[15:0]};
            e.npc   = id_npc;
            e.a     = a_rd;
            e.b     = b_rd;
`ifdef WB_BYPASS_EN
            if (wb_regwrite && wb_rd == e.rs && e.rs != 5'd0) e.a = wb_writedata;
            if (wb_regwrite && wb_rd == e.rt && e.rt != 5'd0) e.b = wb_writedata;
`endif
        end
        return e;
    endfunction

    function automatic ex_t pick(input int k, input ex_t last);
        if (k == CAP) return cap();
        if (k == HLD) return last;
        return '0;
    endfunction

    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] npc,
                        input logic [8:0] c, input logic ext, input logic fl,
                        input logic es1, input logic es3, input int k1, input int k3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        id_valid = v; id_instr = ins; id_npc = npc; id_ctl = c;
        a_rd = ga; b_rd = gb;
        wb_regwrite = gwbw; wb_rd = gwbrd; wb_writedata = gwbd;
        ext_stall = ext; flush = fl;
        push(cyc, 1, 1'b0, es1, '0);
        push(cyc, 3, 1'b0, es3, '0);
        last1 = pick(k1, last1);
        last3 = pick(k3, last3);
        push(cyc + 1, 1, 1'b1, 1'b0, last1);
        push(cyc + 1, 3, 1'b1, 1'b0, last3);
    endtask

    // Lets the pending capture land and get checked, then asserts reset mid-cycle.
    task automatic rstep();
        @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
        last1 = '0;
        last3 = '0;
        push(cyc + 1, 1, 1'b0, 1'b0, '0);
        push(cyc + 1, 3, 1'b0, 1'b0, '0);
        push(cyc + 1, 1, 1'b1, 1'b0, '0);
        push(cyc + 1, 3, 1'b1, 1'b0, '0);
    endtask

    always @(negedge clk) begin
        exp_t x;
        ex_t  act;
        logic s;
        while (q.size() > 0 && q[0].due <= cyc) begin
            x = q.pop_front();
            total++;
            if (x.is_ex) begin
                act = (x.inst == 1) ? act1 : act3;
                if (act !== x.e) begin
                    bad++;
                    $display("FAIL ex_regs_L%0d cyc=%0d got=%h want=%h", x.inst, cyc, act, x.e);
                end
            end else begin
                s = (x.inst == 1) ? s1 : s3;
                if (s !== x.s) begin
                    bad++;
                    $display("FAIL stall_L%0d cyc=%0d got=%b want=%b", x.inst, cyc, s, x.s);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        id_valid = 1'b1; id_instr = LW; id_npc = 32'h100; id_ctl = CLW;
        a_rd = 0; b_rd = 0; wb_regwrite = 0; wb_rd = 0; wb_writedata = 0;
        ext_stall = 0; flush = 0;
        last1 = '0; last3 = '0;
        rstep();
        rstep();
        ga = 32'hA0A0_0001; gb = 32'hB0B0_0002;
        // load-use: L=1 stalls once, L=3 stalls three times
        step(1, LW,   32'h100, CLW,  0, 0, 0, 0, CAP, CAP);
        step(1, ADD,  32'h104, CADD, 0, 0, 1, 1, BUB, BUB);
        step(1, ADD,  32'h104, CADD, 0, 0, 0, 1, CAP, BUB);
        step(1, ADD,  32'h104, CADD, 0, 0, 0, 1, CAP, BUB);
        step(1, ADD,  32'h104, CADD, 0, 0, 0, 0, CAP, CAP);
        // ext_stall freezes HOLD and EX
        step(1, LWN,  32'h108, CLW,  0, 0, 0, 0, CAP, CAP);
        step(1, ADD,  32'h10C, CADD, 0, 0, 1, 1, BUB, BUB);
        step(1, ADD,  32'h10C, CADD, 1, 0, 1, 1, HLD, HLD);
        step(1, ADD,  32'h10C, CADD, 1, 0, 1, 1, HLD, HLD);
        step(1, ADD,  32'h10C, CADD, 0, 0, 0, 1, CAP, BUB);
        step(1, ADD,  32'h10C, CADD, 0, 0, 0, 1, CAP, BUB);
        step(1, ADD,  32'h10C, CADD, 0, 0, 0, 0, CAP, CAP);
        // flush during HOLD, then flush suppressing a hazard in RUN
        step(1, LW,   32'h110, CLW,  0, 0, 0, 0, CAP, CAP);
        step(1, ADD,  32'h114, CADD, 0, 0, 1, 1, BUB, BUB);
        step(1, ADD,  32'h114, CADD, 0, 1, 0, 0, BUB, BUB);
        step(1, SUB,  32'h118, CADD, 0, 0, 0, 0, CAP, CAP);
        step(1, LW,   32'h11C, CLW,  0, 0, 0, 0, CAP, CAP);
        step(1, ADD,  32'h120, CADD, 0, 1, 0, 0, BUB, BUB);
        step(1, ADD,  32'h124, CADD, 0, 0, 0, 0, CAP, CAP);
        // load to $0 never hazards; invalid ID never hazards
        step(1, LW0,  32'h128, CLW,  0, 0, 0, 0, CAP, CAP);
        step(1, ADD0, 32'h12C, CADD, 0, 0, 0, 0, CAP, CAP);
        step(1, LW,   32'h130, CLW,  0, 0, 0, 0, CAP, CAP);
        step(0, ADD,  32'h134, CADD, 0, 0, 0, 0, CAP, CAP);
        step(1, ADD,  32'h138, CADD, 0, 0, 0, 0, CAP, CAP);
        // writeback bypass vectors
        ga = 32'h1111_1111; gb = 32'h2222_2222;
        gwbw = 1; gwbrd = 5'd5; gwbd = 32'hDEAD_BEEF;
        step(1, BYA,  32'h13C, CADD, 0, 0, 0, 0, CAP, CAP);
        gwbrd = 5'd0;
        step(1, BYB,  32'h140, CADD, 0, 0, 0, 0, CAP, CAP);
        gwbrd = 5'd5;
        step(1, BYB,  32'h144, CADD, 0, 0, 0, 0, CAP, CAP);
        gwbw = 0; gwbrd = 5'd0; gwbd = 32'h0;
        ga = 32'hA0A0_0003; gb = 32'hB0B0_0004;
        // reset while L=3 sits in HOLD
        step(1, LW,   32'h148, CLW,  0, 0, 0, 0, CAP, CAP);
        step(1, ADD,  32'h14C, CADD, 0, 0, 1, 1, BUB, BUB);
        rstep();
        step(1, ADD,  32'h14C, CADD, 0, 0, 0, 0, CAP, CAP);
        step(1, SUB,  32'h150, CADD, 0, 0, 0, 0, CAP, CAP);
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got=%0d pending want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
